// File: rtl/doorlock_pkg.sv
// Shared types and default timing for the multi-door lock controller.
package doorlock_pkg;

  localparam int unsigned CLK_HZ           = 50000000;
  localparam int unsigned UNLOCK_SEC       = 3;
  localparam int unsigned UNLOCK_DEFAULT   = CLK_HZ * UNLOCK_SEC;
  localparam int unsigned COOLDOWN_DEFAULT = CLK_HZ / 2;

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    UNLOCKED = 2'b01,
    COOLDOWN = 2'b10
  } door_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/doorlock_channel.sv
// One door: registered availability flag, LOCKED/UNLOCKED/COOLDOWN FSM and a shared down-timer.
module doorlock_channel
  import doorlock_pkg::*;
#(
  parameter int unsigned UNLOCK_CYCLES   = UNLOCK_DEFAULT,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_DEFAULT,
  parameter int unsigned RETRIGGER       = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic available,
  input  logic unavailable,
  input  logic unlock_req,
  output logic lock_output,
  output logic room_available,
  output logic reject,
  output logic busy
);

  localparam int unsigned TIMER_W = $clog2(max_u(UNLOCK_CYCLES, COOLDOWN_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] UNLOCK_LOAD = TIMER_W'(UNLOCK_CYCLES - 1);
  localparam logic [TIMER_W-1:0] COOL_LOAD =
      TIMER_W'((COOLDOWN_CYCLES > 0) ? COOLDOWN_CYCLES - 1 : 0);

  door_state_e        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d, timer_dec;
  logic               avail_q, avail_d;
  logic               reject_q, reject_d;
  logic               eff_avail;

  // A same-cycle unavailable overrides the stored flag for this cycle's decision.
  assign eff_avail = avail_q && !unavailable;
  assign timer_dec = (timer_q == '0) ? '0 : timer_q - 1'b1;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    reject_d = 1'b0;
    avail_d  = unavailable ? 1'b0 : (available ? 1'b1 : avail_q);
    case (state_q)
      LOCKED: begin
        if (unlock_req) begin
          if (eff_avail) begin
            state_d = UNLOCKED;
            timer_d = UNLOCK_LOAD;
          end else begin
            reject_d = 1'b1;
          end
        end
      end
      UNLOCKED: begin
        if (!eff_avail || (timer_q == '0 && !(unlock_req && RETRIGGER != 0))) begin
          state_d = (COOLDOWN_CYCLES == 0) ? LOCKED : COOLDOWN;
          timer_d = (COOLDOWN_CYCLES == 0) ? '0 : COOL_LOAD;
        end else if (unlock_req && RETRIGGER != 0) begin
          timer_d = UNLOCK_LOAD;
        end else begin
          timer_d = timer_dec;
        end
      end
      COOLDOWN: begin
        reject_d = unlock_req;
        if (timer_q == '0) begin
          state_d = LOCKED;
        end else begin
          timer_d = timer_dec;
        end
      end
      default: begin
        state_d = LOCKED;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= LOCKED;
      timer_q  <= '0;
      avail_q  <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      avail_q  <= avail_d;
      reject_q <= reject_d;
    end
  end

  assign lock_output    = (state_q == UNLOCKED);
  assign busy           = (state_q == UNLOCKED) || (state_q == COOLDOWN);
  assign room_available = avail_q;
  assign reject         = reject_q;

endmodule

// File: rtl/multi_doorlock.sv
// N_DOORS independent door-lock channels sharing one clock and reset.
module multi_doorlock
  import doorlock_pkg::*;
#(
  parameter int unsigned N_DOORS         = 4,
  parameter int unsigned UNLOCK_CYCLES   = UNLOCK_DEFAULT,
  parameter int unsigned COOLDOWN_CYCLES = COOLDOWN_DEFAULT,
  parameter int unsigned RETRIGGER       = 1
) (
  input  logic               FPGA_CLK1_50,
  input  logic               reset,
  input  logic [N_DOORS-1:0] available,
  input  logic [N_DOORS-1:0] unavailable,
  input  logic [N_DOORS-1:0] unlock_req,
  output logic [N_DOORS-1:0] lock_output,
  output logic [N_DOORS-1:0] room_available,
  output logic [N_DOORS-1:0] reject,
  output logic [N_DOORS-1:0] busy
);

  for (genvar g = 0; g < N_DOORS; g++) begin : g_door
    doorlock_channel #(
      .UNLOCK_CYCLES  (UNLOCK_CYCLES),
      .COOLDOWN_CYCLES(COOLDOWN_CYCLES),
      .RETRIGGER      (RETRIGGER)
    ) u_channel (
      .clk           (FPGA_CLK1_50),
      .reset         (reset),
      .available     (available[g]),
      .unavailable   (unavailable[g]),
      .unlock_req    (unlock_req[g]),
      .lock_output   (lock_output[g]),
      .room_available(room_available[g]),
      .reject        (reject[g]),
      .busy          (busy[g])
    );
  end

endmodule

// File: tb/tb_multi_doorlock.sv
// Random and directed stimulus on two configurations against a time-window reference model.
module tb_multi_doorlock;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] avail, unav, req;

  logic [1:0] lock_a, room_a, rej_a, busy_a;
  logic [2:0] lock_b, room_b, rej_b, busy_b;

  always #5 clk = ~clk;

  // Configuration A: the verification setup. B: no retrigger, no cooldown.
  multi_doorlock #(
    .N_DOORS(2), .UNLOCK_CYCLES(10), .COOLDOWN_CYCLES(4), .RETRIGGER(1)
  ) dut_a (
    .FPGA_CLK1_50  (clk),
    .reset         (rst),
    .available     (avail[1:0]),
    .unavailable   (unav[1:0]),
    .unlock_req    (req[1:0]),
    .lock_output   (lock_a),
    .room_available(room_a),
    .reject        (rej_a),
    .busy          (busy_a)
  );

  multi_doorlock #(
    .N_DOORS(3), .UNLOCK_CYCLES(5), .COOLDOWN_CYCLES(0), .RETRIGGER(0)
  ) dut_b (
    .FPGA_CLK1_50  (clk),
    .reset         (rst),
    .available     (avail),
    .unavailable   (unav),
    .unlock_req    (req),
    .lock_output   (lock_b),
    .room_available(room_b),
    .reject        (rej_b),
    .busy          (busy_b)
  );

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  int uc[2] = '{10, 5};
  int cc[2] = '{4, 0};
  int rt[2] = '{1, 0};
  int nd[2] = '{2, 3};

  // Model: lock is open after edges up to open_end, busy up to cool_end (edge indices).
  int open_end[2][3];
  int cool_end[2][3];
  bit room[2][3];
  bit rej[2][3];

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step(input int e);
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < nd[i]; d++) begin
        rej[i][d] = 1'b0;
        if (rst) begin
          open_end[i][d] = -100;
          cool_end[i][d] = -100;
          room[i][d]     = 1'b0;
        end else begin
          bit ok;
          ok = room[i][d] && !unav[d];
          if (e - 1 <= open_end[i][d]) begin
            if (!ok) begin
              open_end[i][d] = e - 1;
              cool_end[i][d] = e - 1 + cc[i];
            end else if (req[d] && rt[i] != 0) begin
              open_end[i][d] = e + uc[i] - 1;
              cool_end[i][d] = open_end[i][d] + cc[i];
            end
          end else if (e - 1 <= cool_end[i][d]) begin
            rej[i][d] = req[d];
          end else if (req[d]) begin
            if (ok) begin
              open_end[i][d] = e + uc[i] - 1;
              cool_end[i][d] = open_end[i][d] + cc[i];
            end else begin
              rej[i][d] = 1'b1;
            end
          end
          if (unav[d]) room[i][d] = 1'b0;
          else if (avail[d]) room[i][d] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all(input int e);
    logic [2:0] lk[2], rm[2], rj[2], bz[2];
    lk[0] = {1'b0, lock_a}; rm[0] = {1'b0, room_a}; rj[0] = {1'b0, rej_a}; bz[0] = {1'b0, busy_a};
    lk[1] = lock_b;         rm[1] = room_b;         rj[1] = rej_b;         bz[1] = busy_b;
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < nd[i]; d++) begin
        string sfx;
        sfx = $sformatf("cfg%0d door%0d edge%0d", i, d, e);
        check({"lock ", sfx}, int'(lk[i][d]), int'(e <= open_end[i][d]));
        check({"busy ", sfx}, int'(bz[i][d]), int'(e <= cool_end[i][d]));
        check({"room ", sfx}, int'(rm[i][d]), int'(room[i][d]));
        check({"reject ", sfx}, int'(rj[i][d]), int'(rej[i][d]));
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [2:0] a, input logic [2:0] u,
                       input logic [2:0] q);
    rst = r; avail = a; unav = u; req = q;
    @(posedge clk);
    model_step(edge_n);
    #1;
    compare_all(edge_n);
    edge_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(1'b0, 3'b000, 3'b000, 3'b000);
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int d = 0; d < 3; d++) begin
        open_end[i][d] = -100; cool_end[i][d] = -100;
        room[i][d] = 1'b0; rej[i][d] = 1'b0;
      end
    rst = 1'b1; avail = '0; unav = '0; req = '0;
    cycle(1'b1, 3'b111, 3'b000, 3'b111);
    cycle(1'b1, 3'b000, 3'b000, 3'b000);
    // Grant, then a request with no availability on door 1.
    cycle(1'b0, 3'b001, 3'b000, 3'b000);
    idle(2);
    cycle(1'b0, 3'b000, 3'b000, 3'b011);
    idle(4);
    cycle(1'b0, 3'b000, 3'b000, 3'b001);
    idle(20);
    // Forced relock, request during cooldown, regrant.
    cycle(1'b0, 3'b111, 3'b000, 3'b000);
    cycle(1'b0, 3'b000, 3'b000, 3'b111);
    idle(2);
    cycle(1'b0, 3'b000, 3'b111, 3'b000);
    idle(1);
    cycle(1'b0, 3'b111, 3'b000, 3'b111);
    idle(3);
    cycle(1'b0, 3'b000, 3'b000, 3'b111);
    idle(3);
    // Available, unavailable and request together.
    cycle(1'b0, 3'b111, 3'b111, 3'b111);
    idle(2);
    // Reset in the middle of an unlock, then a normal grant.
    cycle(1'b0, 3'b111, 3'b000, 3'b111);
    idle(2);
    cycle(1'b1, 3'b000, 3'b000, 3'b000);
    cycle(1'b0, 3'b111, 3'b000, 3'b000);
    cycle(1'b0, 3'b000, 3'b000, 3'b111);
    idle(20);
    for (int k = 0; k < 4000; k++) begin
      logic [2:0] a, u, q;
      for (int d = 0; d < 3; d++) begin
        a[d] = ($urandom_range(0, 7) == 0);
        u[d] = ($urandom_range(0, 40) == 0);
        q[d] = ($urandom_range(0, 3) == 0);
      end
      cycle(($urandom_range(0, 600) == 0), a, u, q);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
